// File: rtl/apb_intercon_rr.sv
// apb_intercon_rr: registered N-master to M-slave APB interconnect with round-robin grant,
// address-map decode and error response for unmapped or timed-out accesses.
module apb_intercon_rr #(
  parameter int BUS_WIDTH = 16,
  parameter int MASTER_PORTS = 4,
  parameter int SLAVE_PORTS = 4,
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_BASE = {16'h8000, 16'h0100, 16'h00B0, 16'h00A0},
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_MASK = {16'h8000, 16'hFF00, 16'hFFF0, 16'hFFF0},
  parameter int TIMEOUT = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]           S_PWRITE,
  input  logic [MASTER_PORTS-1:0]           S_PSELx,
  input  logic [MASTER_PORTS-1:0]           S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]           S_PREADY,
  output logic [MASTER_PORTS-1:0]           S_PSLVERR,
  output logic [BUS_WIDTH-1:0]              M_PADDR,
  output logic                              M_PWRITE,
  output logic [SLAVE_PORTS-1:0]            M_PSELx,
  output logic                              M_PENABLE,
  output logic [BUS_WIDTH-1:0]              M_PWDATA,
  input  logic [BUS_WIDTH-1:0]              M_PRDATA,
  input  logic                              M_PREADY,
  input  logic                              M_PSLVERR
);
  localparam int GW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
  localparam int SW = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;
  state_t state_q;
  logic [GW-1:0] grant_q, last_q, win_d;
  logic [SW-1:0] slv_q, slv_d;
  logic [BUS_WIDTH-1:0] addr_q, wdata_q, addr_d, wdata_d, rdata;
  logic write_q, write_d, req, hit, active, fin, ferr, tmo;
  logic [TW-1:0] timer_q;
  logic unused_penable;
  int j;
  assign unused_penable = ^S_PENABLE;
  assign tmo = (TIMEOUT != 0) && (state_q == ACCESS) && !M_PREADY && (timer_q == TW'(TIMEOUT - 1));
  // Rotating search starts just after the last winner, so a repeat requester yields to others.
  always_comb begin
    j = 0;
    req = 1'b0;
    win_d = '0;
    addr_d = '0;
    wdata_d = '0;
    write_d = 1'b0;
    for (int k = 1; k <= MASTER_PORTS; k++) begin
      j = (int'(last_q) + k) % MASTER_PORTS;
      if (!req && S_PSELx[j]) begin
        req = 1'b1;
        win_d = GW'(j);
        addr_d = S_PADDR[j*BUS_WIDTH +: BUS_WIDTH];
        wdata_d = S_PWDATA[j*BUS_WIDTH +: BUS_WIDTH];
        write_d = S_PWRITE[j];
      end
    end
    hit = 1'b0;
    slv_d = '0;
    for (int i = SLAVE_PORTS - 1; i >= 0; i--)
      if ((addr_d & SLAVE_MASK[i*BUS_WIDTH +: BUS_WIDTH]) == SLAVE_BASE[i*BUS_WIDTH +: BUS_WIDTH]) begin
        hit = 1'b1;
        slv_d = SW'(i);
      end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(MASTER_PORTS - 1);
      slv_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          grant_q <= win_d;
          last_q  <= win_d;
          slv_q   <= slv_d;
          addr_q  <= addr_d;
          wdata_q <= wdata_d;
          write_q <= write_d;
          state_q <= hit ? SETUP : ERR;
        end
        SETUP: state_q <= ACCESS;
        ACCESS: begin
          state_q <= (M_PREADY || tmo) ? IDLE : ACCESS;
          timer_q <= (M_PREADY || tmo) ? '0 : timer_q + TW'(1);
        end
        ERR: state_q <= IDLE;
      endcase
    end
  end
  // Bus side is gated by state so nothing stale leaks out in IDLE or ERR.
  always_comb begin
    active = (state_q == SETUP) || (state_q == ACCESS);
    fin = ((state_q == ACCESS) && M_PREADY) || tmo || (state_q == ERR);
    ferr = (state_q == ERR) || tmo || M_PSLVERR;
    rdata = ((state_q == ACCESS) && M_PREADY) ? M_PRDATA : '0;
    M_PENABLE = state_q == ACCESS;
    M_PADDR = active ? addr_q : '0;
    M_PWDATA = active ? wdata_q : '0;
    M_PWRITE = active && write_q;
    M_PSELx = '0;
    for (int i = 0; i < SLAVE_PORTS; i++) M_PSELx[i] = active && (slv_q == SW'(i));
    S_PREADY = '0;
    S_PSLVERR = '0;
    S_PRDATA = '0;
    for (int m = 0; m < MASTER_PORTS; m++)
      if (fin && (grant_q == GW'(m))) begin
        S_PREADY[m] = 1'b1;
        S_PSLVERR[m] = ferr;
        S_PRDATA[m*BUS_WIDTH +: BUS_WIDTH] = rdata;
      end
  end
endmodule

// File: tb/tb_apb_intercon_rr.sv
// tb_apb_intercon_rr: directed bench with a transaction-level model of the interconnect,
// per-cycle output comparison and hand-computed checks for each scenario.
module tb_apb_intercon_rr;
  localparam int BW = 16, MP = 4, SP = 4, TMO = 8;
  localparam logic [SP*BW-1:0] BASE = {16'h8000, 16'h0100, 16'h00B0, 16'h00A0};
  localparam logic [SP*BW-1:0] MASK = {16'h8000, 16'hFF00, 16'hFFF0, 16'hFFF0};
  logic clk = 1'b0, reset = 1'b0;
  logic [MP*BW-1:0] s_paddr = '0, s_pwdata = '0, s_prdata;
  logic [MP-1:0] s_pwrite = '0, s_psel = '0, s_penable = '0, s_pready, s_pslverr;
  logic [BW-1:0] m_paddr, m_pwdata, m_prdata;
  logic m_pwrite, m_penable, m_pready, m_pslverr;
  logic [SP-1:0] m_psel;
  int ready_at = 1, acc_cnt = 0;
  logic [BW-1:0] s_rdata = 16'h5A5A;
  logic s_err = 1'b0;
  int n_left[MP], req_cyc[MP], cyc = 0;
  logic [BW-1:0] cf_addr[MP], cf_wdata[MP];
  logic cf_wr[MP], cmp_done[MP];
  int md_off = 0, md_last = MP - 1, md_g = 0, md_slv = 0;
  logic [BW-1:0] md_addr = '0, md_wdata = '0;
  logic md_wr = 1'b0;
  int done_q[$], err_q[$], rd_q[$], rdy_q[$];
  int pen_cnt = 0;
  logic [BW-1:0] last_wd = '0;
  logic [SP-1:0] seen_sel = '0;
  int checks = 0, errors = 0;

  apb_intercon_rr #(.BUS_WIDTH(BW), .MASTER_PORTS(MP), .SLAVE_PORTS(SP), .SLAVE_BASE(BASE),
                    .SLAVE_MASK(MASK), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .S_PADDR(s_paddr), .S_PWRITE(s_pwrite), .S_PSELx(s_psel),
    .S_PENABLE(s_penable), .S_PWDATA(s_pwdata), .S_PRDATA(s_prdata), .S_PREADY(s_pready),
    .S_PSLVERR(s_pslverr), .M_PADDR(m_paddr), .M_PWRITE(m_pwrite), .M_PSELx(m_psel),
    .M_PENABLE(m_penable), .M_PWDATA(m_pwdata), .M_PRDATA(m_prdata), .M_PREADY(m_pready),
    .M_PSLVERR(m_pslverr));

  always #5 clk = ~clk;

  // Slave: ready on the ready_at-th ACCESS cycle (0 = never)
  assign m_pready = m_penable && (acc_cnt + 1 == ready_at);
  assign m_prdata = s_rdata;
  assign m_pslverr = s_err;
  always @(posedge clk) acc_cnt <= (m_penable && !m_pready) ? acc_cnt + 1 : 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int dec(input logic [BW-1:0] a);
    for (int i = 0; i < SP; i++)
      if ((a & MASK[i*BW +: BW]) == BASE[i*BW +: BW]) return i;
    return -1;
  endfunction

  function automatic int qv(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Masters: hold select while transactions remain, count one off per observed completion
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    for (int m = 0; m < MP; m++) begin
      if (cmp_done[m]) begin
        cmp_done[m] = 1'b0;
        if (n_left[m] > 0) n_left[m]--;
      end
      if (n_left[m] > 0 && !s_psel[m]) req_cyc[m] = cyc;
      s_psel[m] = n_left[m] > 0;
      s_paddr[m*BW +: BW] = cf_addr[m];
      s_pwdata[m*BW +: BW] = cf_wdata[m];
      s_pwrite[m] = cf_wr[m];
    end
  end

  // Model: md_off counts cycles since a transaction was accepted (1 = setup, k>1 = access k-1)
  always @(negedge clk) begin
    logic [SP-1:0] e_sel;
    logic e_en, e_wr, dn, found;
    logic [BW-1:0] e_addr, e_wd;
    logic [MP-1:0] e_rdy, e_err;
    logic [MP*BW-1:0] e_rd;
    int n, jj;
    e_sel = '0; e_en = 1'b0; e_wr = 1'b0; dn = 1'b0; e_addr = '0; e_wd = '0;
    e_rdy = '0; e_err = '0; e_rd = '0; n = 0; found = 1'b0;
    if (!reset) begin
      md_off = 0;
      md_last = MP - 1;
    end else if (md_off > 0) begin
      if (md_slv < 0) begin
        dn = 1'b1; e_rdy[md_g] = 1'b1; e_err[md_g] = 1'b1;
      end else begin
        n = md_off - 1;
        e_sel[md_slv] = 1'b1; e_en = n > 0; e_addr = md_addr; e_wd = md_wdata; e_wr = md_wr;
        if (n > 0 && n == ready_at) begin
          dn = 1'b1; e_rdy[md_g] = 1'b1; e_err[md_g] = s_err; e_rd[md_g*BW +: BW] = s_rdata;
        end else if (n == TMO) begin
          dn = 1'b1; e_rdy[md_g] = 1'b1; e_err[md_g] = 1'b1;
        end
      end
    end
    chk("M_PSELx", m_psel, e_sel);
    chk("M_PENABLE", m_penable, e_en);
    chk("M_PADDR", m_paddr, e_addr);
    chk("M_PWDATA", m_pwdata, e_wd);
    chk("M_PWRITE", m_pwrite, e_wr);
    chk("S_PREADY", s_pready, e_rdy);
    chk("S_PSLVERR", s_pslverr, e_err);
    chk("S_PRDATA", s_prdata, e_rd);
    if (reset) begin
      for (int m = 0; m < MP; m++)
        if (s_pready[m]) begin
          cmp_done[m] = 1'b1;
          done_q.push_back(m);
          err_q.push_back(int'(s_pslverr[m]));
          rd_q.push_back(int'(s_prdata[m*BW +: BW]));
          rdy_q.push_back(cyc);
        end
      if (m_penable) begin
        pen_cnt++;
        last_wd = m_pwdata;
      end
      seen_sel |= m_psel;
      if (md_off > 0) md_off = dn ? 0 : md_off + 1;
      else
        for (int k = 1; k <= MP; k++) begin
          jj = (md_last + k) % MP;
          if (!found && s_psel[jj]) begin
            found = 1'b1;
            md_g = jj; md_last = jj; md_off = 1;
            md_addr = s_paddr[jj*BW +: BW]; md_wdata = s_pwdata[jj*BW +: BW]; md_wr = s_pwrite[jj];
            md_slv = dec(md_addr);
          end
        end
    end
  end

  task automatic start(input int m, input logic [BW-1:0] a, input logic [BW-1:0] d, input logic w, input int cnt);
    cf_addr[m] = a; cf_wdata[m] = d; cf_wr[m] = w; n_left[m] = cnt;
  endtask

  task automatic clear_logs();
    done_q.delete(); err_q.delete(); rd_q.delete(); rdy_q.delete();
    pen_cnt = 0; seen_sel = '0;
  endtask

  task automatic wait_idle();
    int b;
    logic busy;
    b = 0;
    repeat (2) @(posedge clk);
    while (b < 300) begin
      busy = (md_off != 0) || (s_psel != '0);
      for (int m = 0; m < MP; m++) busy |= n_left[m] != 0;
      if (!busy) break;
      @(posedge clk);
      b++;
    end
    if (b >= 300) begin
      checks++; errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", b);
    end
    #3;
  endtask

  initial begin
    int ord[5];
    int b;
    ord = '{0, 1, 2, 3, 0};
    for (int m = 0; m < MP; m++) begin
      n_left[m] = 0; req_cyc[m] = 0; cf_addr[m] = '0; cf_wdata[m] = '0; cf_wr[m] = 1'b0; cmp_done[m] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel", m_psel, 4'b0000);
    chk("rst_pready", s_pready, 4'b0000);
    #2 reset = 1'b1;
    // all four request together, master0 twice
    @(posedge clk); #3;
    clear_logs();
    start(0, 16'h00A4, 16'h1111, 1'b1, 2);
    start(1, 16'h00B0, 16'h2222, 1'b0, 1);
    start(2, 16'h0120, 16'h3333, 1'b1, 1);
    start(3, 16'h8000, 16'h4444, 1'b0, 1);
    wait_idle();
    chk("t2_count", done_q.size(), 5);
    for (int i = 0; i < 5; i++) chk("t2_order", qv(done_q, i), ord[i]);
    // master0 write to GPIO
    clear_logs();
    start(0, 16'h00A0, 16'h1234, 1'b1, 1);
    wait_idle();
    chk("t1_latency", qv(rdy_q, 0) - req_cyc[0], 2);
    chk("t1_sel", seen_sel, 4'b0001);
    chk("t1_wdata", last_wd, 16'h1234);
    chk("t1_pen", pen_cnt, 1);
    chk("t1_err", qv(err_q, 0), 0);
    // unmapped read
    clear_logs();
    start(1, 16'h0050, 16'h0000, 1'b0, 1);
    wait_idle();
    chk("t3_sel", seen_sel, 4'b0000);
    chk("t3_who", qv(done_q, 0), 1);
    chk("t3_err", qv(err_q, 0), 1);
    chk("t3_rdata", qv(rd_q, 0), 0);
    chk("t3_latency", qv(rdy_q, 0) - req_cyc[1], 1);
    // slave never ready -> timeout
    ready_at = 0;
    clear_logs();
    start(3, 16'h00B8, 16'h0000, 1'b0, 1);
    wait_idle();
    chk("t4_pen", pen_cnt, 8);
    chk("t4_err", qv(err_q, 0), 1);
    chk("t4_rdata", qv(rd_q, 0), 0);
    chk("t4_sel", seen_sel, 4'b0010);
    // wait states, read data returned
    ready_at = 3;
    s_rdata = 16'hBEEF;
    clear_logs();
    start(2, 16'h0104, 16'h0000, 1'b0, 1);
    wait_idle();
    chk("t5_rdata", qv(rd_q, 0), 16'hBEEF);
    chk("t5_err", qv(err_q, 0), 0);
    chk("t5_pen", pen_cnt, 3);
    chk("t5_latency", qv(rdy_q, 0) - req_cyc[2], 4);
    // reset mid-ACCESS, then arbitration restarts at master0
    ready_at = 1;
    clear_logs();
    start(1, 16'hC000, 16'h0077, 1'b1, 1);
    wait_idle();
    ready_at = 0;
    start(2, 16'h00A8, 16'h0000, 1'b0, 1);
    b = 0;
    while (!m_penable && b < 20) begin
      @(negedge clk);
      b++;
    end
    chk("t6_access", m_penable, 1'b1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("t6_psel", m_psel, 4'b0000);
    chk("t6_penable", m_penable, 1'b0);
    chk("t6_paddr", m_paddr, 16'h0000);
    chk("t6_pready", s_pready, 4'b0000);
    for (int m = 0; m < MP; m++) n_left[m] = 0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    ready_at = 1;
    clear_logs();
    for (int m = 0; m < MP; m++) start(m, 16'h0100 + BW'(m), 16'h0000, 1'b0, 1);
    wait_idle();
    chk("t6_first", qv(done_q, 0), 0);
    chk("t6_count", done_q.size(), 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
